// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request sequencer: function codes, legality check and FSM states.
package alu_pkg;

  localparam int FN_W = 6;

  localparam logic [FN_W-1:0] FUNCT_AND = 6'd36;
  localparam logic [FN_W-1:0] FUNCT_OR  = 6'd37;
  localparam logic [FN_W-1:0] FUNCT_ADD = 6'd32;
  localparam logic [FN_W-1:0] FUNCT_SUB = 6'd34;
  localparam logic [FN_W-1:0] FUNCT_SLT = 6'd42;

  typedef enum logic {IDLE, EXEC} state_t;

  function automatic logic is_legal(input logic [FN_W-1:0] f);
    return (f == FUNCT_AND) || (f == FUNCT_OR) || (f == FUNCT_ADD) ||
           (f == FUNCT_SUB) || (f == FUNCT_SLT);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (req[0] && req[1]) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: capture a request, hold it on the ALU for one cycle,
// then return the result (or an illegal-code error) as a one-cycle pulse to the winner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_dataA,
  input  logic [WIDTH-1:0]   req0_dataB,
  input  logic [FUNCT_W-1:0] req0_Signal,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_dataA,
  input  logic [WIDTH-1:0]   req1_dataB,
  input  logic [FUNCT_W-1:0] req1_Signal,
  output logic               resp0_valid,
  output logic [WIDTH-1:0]   resp0_dataOut,
  output logic               resp0_error,
  output logic               resp1_valid,
  output logic [WIDTH-1:0]   resp1_dataOut,
  output logic               resp1_error,
  output logic [WIDTH-1:0]   alu_dataA,
  output logic [WIDTH-1:0]   alu_dataB,
  output logic [FUNCT_W-1:0] alu_Signal,
  input  logic [WIDTH-1:0]   alu_dataOut,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  state_t     state_q, state_d;
  logic [1:0] grant;
  logic       accept;
  logic       win_p0;
  logic       legal_p1;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign req0_ready = (state_q == IDLE) && grant[0];
  assign req1_ready = (state_q == IDLE) && grant[1];
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign busy       = (state_q == EXEC);
  assign legal_p1   = is_legal(FN_W'(alu_Signal));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: operands captured on accept; stage p1: result captured at the end of EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_p0        <= 1'b0;
      alu_dataA     <= '0;
      alu_dataB     <= '0;
      alu_Signal    <= '0;
      resp0_valid   <= 1'b0;
      resp0_dataOut <= '0;
      resp0_error   <= 1'b0;
      resp1_valid   <= 1'b0;
      resp1_dataOut <= '0;
      resp1_error   <= 1'b0;
      op_count      <= '0;
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      if (accept) begin
        win_p0     <= grant[1];
        alu_dataA  <= grant[1] ? req1_dataA  : req0_dataA;
        alu_dataB  <= grant[1] ? req1_dataB  : req0_dataB;
        alu_Signal <= grant[1] ? req1_Signal : req0_Signal;
      end
      if (state_q == EXEC) begin
        if (win_p0) begin
          resp1_valid   <= 1'b1;
          resp1_dataOut <= legal_p1 ? alu_dataOut : '0;
          resp1_error   <= !legal_p1;
        end else begin
          resp0_valid   <= 1'b1;
          resp0_dataOut <= legal_p1 ? alu_dataOut : '0;
          resp0_error   <= !legal_p1;
        end
        if (legal_p1) begin
          op_count <= op_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model and per-cycle compare.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int FW = 6;
  localparam int CW = 8;

  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_SLT = 6'd42;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0]  req0_dataA, req0_dataB, req1_dataA, req1_dataB;
  logic [FW-1:0] req0_Signal, req1_Signal;
  logic          resp0_valid, resp1_valid, resp0_error, resp1_error;
  logic [W-1:0]  resp0_dataOut, resp1_dataOut;
  logic [W-1:0]  alu_dataA, alu_dataB, alu_dataOut;
  logic [FW-1:0] alu_Signal;
  logic          busy;
  logic [CW-1:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .FUNCT_W(FW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dataA(req0_dataA),
    .req0_dataB(req0_dataB), .req0_Signal(req0_Signal),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dataA(req1_dataA),
    .req1_dataB(req1_dataB), .req1_Signal(req1_Signal),
    .resp0_valid(resp0_valid), .resp0_dataOut(resp0_dataOut), .resp0_error(resp0_error),
    .resp1_valid(resp1_valid), .resp1_dataOut(resp1_dataOut), .resp1_error(resp1_error),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_Signal(alu_Signal),
    .alu_dataOut(alu_dataOut), .busy(busy), .op_count(op_count)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f);
    case (f)
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [5:0] f);
    return f inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT};
  endfunction

  // The ALU itself is part of the environment.
  always_comb alu_dataOut = ref_alu(alu_dataA, alu_dataB, alu_Signal);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one pending operation, round-robin on ties, result one edge after capture.
  logic          m_busy, m_last, m_id;
  logic [31:0]   m_a, m_b;
  logic [5:0]    m_f;
  logic          e_rv0, e_rv1, e_re0, e_re1;
  logic [31:0]   e_rd0, e_rd1;
  logic [CW-1:0] e_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_last = 1; m_id = 0; m_a = 0; m_b = 0; m_f = 0;
      e_rv0 = 0; e_rv1 = 0; e_re0 = 0; e_re1 = 0; e_rd0 = 0; e_rd1 = 0; e_cnt = 0;
    end else begin
      e_rv0 = 0;
      e_rv1 = 0;
      if (m_busy) begin
        m_busy = 0;
        if (m_id) begin
          e_rv1 = 1; e_re1 = !ref_legal(m_f); e_rd1 = ref_legal(m_f) ? ref_alu(m_a, m_b, m_f) : 0;
        end else begin
          e_rv0 = 1; e_re0 = !ref_legal(m_f); e_rd0 = ref_legal(m_f) ? ref_alu(m_a, m_b, m_f) : 0;
        end
        if (ref_legal(m_f)) e_cnt = e_cnt + 1;
      end else if (req0_valid || req1_valid) begin
        m_id = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        m_a  = m_id ? req1_dataA  : req0_dataA;
        m_b  = m_id ? req1_dataB  : req0_dataB;
        m_f  = m_id ? req1_Signal : req0_Signal;
        m_busy = 1;
        m_last = m_id;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("ready0", req0_ready, !m_busy && req0_valid && (!req1_valid || m_last));
      chk("ready1", req1_ready, !m_busy && req1_valid && (!req0_valid || !m_last));
      chk("busy", busy, m_busy);
      chk("resp0_valid", resp0_valid, e_rv0);
      chk("resp1_valid", resp1_valid, e_rv1);
      chk("resp0_dataOut", resp0_dataOut, e_rd0);
      chk("resp1_dataOut", resp1_dataOut, e_rd1);
      chk("resp0_error", resp0_error, e_re0);
      chk("resp1_error", resp1_error, e_re1);
      chk("alu_dataA", alu_dataA, m_a);
      chk("alu_dataB", alu_dataB, m_b);
      chk("alu_Signal", alu_Signal, m_f);
      chk("op_count", op_count, e_cnt);
    end
  end

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    req0_valid = v; req0_dataA = a; req0_dataB = b; req0_Signal = f;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    req1_valid = v; req1_dataA = a; req1_dataB = b; req1_Signal = f;
  endtask

  task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    int k;
    @(posedge clk); #1 set0(1, a, b, f);
    k = 0;
    @(negedge clk);
    while (!req0_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!req0_ready) chk("issue0_ready_timeout", 0, 1);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic gseq[$];
    logic [3:0] gexp;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Lone ADD on req0.
    set0(1, 5, 7, F_ADD);
    @(negedge clk); chk("t1_ready0", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk); chk("t1_busy", busy, 1); chk("t1_no_early_resp", resp0_valid, 0);
    @(negedge clk);
    chk("t1_resp0_valid", resp0_valid, 1);
    chk("t1_resp0_data", resp0_dataOut, 12);
    chk("t1_resp0_err", resp0_error, 0);
    chk("t1_op_count", op_count, 1);
    chk("t1_resp1_quiet", resp1_valid, 0);

    // Tie from reset: req0 SUB wins, req1 SLT accepted in the response cycle.
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    set0(1, 10, 3, F_SUB);
    set1(1, 32'hFFFF_FFFF, 0, F_SLT);
    @(negedge clk); chk("t2_ready0", req0_ready, 1); chk("t2_ready1", req1_ready, 0);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk); chk("t2_busy", busy, 1);
    @(negedge clk);
    chk("t2_resp0_valid", resp0_valid, 1);
    chk("t2_resp0_data", resp0_dataOut, 7);
    chk("t2_ready1_in_resp", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_resp1_valid", resp1_valid, 1);
    chk("t2_resp1_data", resp1_dataOut, 1);
    chk("t2_resp1_err", resp1_error, 0);
    chk("t2_op_count", op_count, 2);

    // Held tie: grants must alternate 0,1,0,1 starting with req0.
    @(posedge clk); #1;
    set0(1, 1, 2, F_ADD);
    set1(1, 3, 4, F_OR);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req0_ready) gseq.push_back(1'b0);
      if (req1_ready) gseq.push_back(1'b1);
    end
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    chk("t3_grant_count", gseq.size(), 4);
    gexp = 4'b1010;
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk("t3_grant_order", gseq[i], gexp[i]);
    repeat (2) @(posedge clk);
    #1;

    // Reset during EXEC of an AND aborts it.
    set0(1, 32'hF0F0, 32'h0FF0, F_AND);
    @(negedge clk); chk("t5_ready0", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk); chk("t5_busy", busy, 1);
    #1 reset = 1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_resp0", resp0_valid, 0);
    chk("t5_rst_data0", resp0_dataOut, 0);
    chk("t5_rst_aluA", alu_dataA, 0);
    chk("t5_rst_aluF", alu_Signal, 0);
    chk("t5_rst_cnt", op_count, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk); chk("t5_no_resp_a", resp0_valid, 0);
    @(negedge clk); chk("t5_no_resp_b", resp0_valid, 0); chk("t5_cnt_after", op_count, 0);
    @(posedge clk); #1 set0(1, 32'hF000, 32'h000F, F_OR);
    @(negedge clk); chk("t5_or_ready", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_or_valid", resp0_valid, 1);
    chk("t5_or_data", resp0_dataOut, 32'hF00F);
    chk("t5_or_cnt", op_count, 1);

    // Illegal code on req1.
    @(posedge clk); #1 set1(1, 9, 9, 6'd0);
    @(negedge clk); chk("t4_ready1", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_resp1_valid", resp1_valid, 1);
    chk("t4_resp1_err", resp1_error, 1);
    chk("t4_resp1_data", resp1_dataOut, 0);
    chk("t4_cnt_held", op_count, 1);

    // Counter wrap (counter built 8 bits wide here).
    for (int i = 0; i < 254; i++) issue0(i, 1, F_ADD);
    chk("t6_cnt_max", op_count, 8'hFF);
    issue0(100, 23, F_ADD);
    chk("t6_wrap_data", resp0_dataOut, 123);
    chk("t6_cnt_wrap", op_count, 0);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
